l2_cache_nway_control: RTL

//  Parametrised N-way set-associative write-back L2 controller; successor to the 2-way controller.

---
 rtl/l2_cache_nway_control.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/l2_cache_nway_control.sv
// N-way set-associative write-back L2 controller with per-set tree pseudo-LRU.
// Define L2_PERF_CNT_EN to build the hit/miss/write-back performance counters.
module l2_cache_nway_control #(
   parameter  int unsigned WAYS  = 4,
   parameter  int unsigned SETS  = 8,
   parameter  int unsigned OFF_W = 4,
   localparam int unsigned TAG_W = 16 - OFF_W - $clog2(SETS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [15:0]               mem_address,
   output logic                      mem_resp,
   output logic                      pmem_read,
   output logic                      pmem_write,
   output logic [15:0]               pmem_address,
   input  logic                      pmem_resp,
   input  logic [WAYS-1:0]           way_hit,
   input  logic [WAYS-1:0]           way_valid,
   input  logic [WAYS-1:0]           way_dirty,
   input  logic [WAYS*TAG_W-1:0]     way_tags,
   output logic [WAYS-1:0]           load_way,
   output logic                      write_type,
   output logic                      cache_in_mux_sel,
   output logic                      insert_mux_sel,
   output logic [$clog2(WAYS)-1:0]   wb_way_sel,
   input  logic                      cnt_clear,
   output logic [15:0]               hit_count,
   output logic [15:0]               miss_count,
   output logic [15:0]               wb_count
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned NODES = WAYS - 1;

   typedef enum logic [1:0] {S_HIT, S_WRITEBACK, S_FETCH, S_INSTALL} state_t;

   state_t             state_q, state_d;
   logic [WAY_W-1:0]   victim_q, victim_d;
   logic [NODES-1:0]   plru_q [SETS];
   logic [NODES-1:0]   plru_d [SETS];

   logic               req, wr;
   logic [IDX_W-1:0]   idx;
   logic               hit_any, inv_any;
   logic [WAY_W-1:0]   hit_way, inv_way, plru_vict;
   logic [TAG_W-1:0]   victim_tag;
   logic               hit_evt, miss_evt, wb_evt;

   // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); bit 0 points left.
   function automatic logic [WAY_W-1:0] plru_pick(input logic [NODES-1:0] bits);
      logic [WAY_W-1:0] v;
      int unsigned      node;
      v    = '0;
      node = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         v    = (v << 1) | WAY_W'(bits[node]);
         node = 2 * node + (bits[node] ? 2 : 1);
      end
      return v;
   endfunction

   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
      logic [NODES-1:0] b;
      int unsigned      node;
      logic             dir;
      b    = bits;
      node = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         dir     = way[WAY_W-1-l];
         b[node] = ~dir;
         node    = 2 * node + (dir ? 2 : 1);
      end
      return b;
   endfunction

   assign req        = mem_read | mem_write;
   assign wr         = mem_write;
   assign idx        = mem_address[OFF_W +: IDX_W];
   assign plru_vict  = plru_pick(plru_q[idx]);
   assign wb_way_sel = victim_q;

   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (way_hit[w] && !hit_any) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!way_valid[w] && !inv_any) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      victim_tag = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (victim_q == WAY_W'(w)) victim_tag = way_tags[w*TAG_W +: TAG_W];
      end
   end

   always_comb begin
      state_d          = state_q;
      victim_d         = victim_q;
      plru_d           = plru_q;
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      pmem_address     = {mem_address[15:OFF_W], {OFF_W{1'b0}}};
      load_way         = '0;
      write_type       = 1'b0;
      cache_in_mux_sel = 1'b0;
      insert_mux_sel   = 1'b0;
      hit_evt          = 1'b0;
      miss_evt         = 1'b0;
      wb_evt           = 1'b0;
      unique case (state_q)
         S_HIT: begin
            if (req && hit_any) begin
               mem_resp    = 1'b1;
               hit_evt     = 1'b1;
               plru_d[idx] = plru_touch(plru_q[idx], hit_way);
               if (wr) begin
                  load_way         = WAYS'(1) << hit_way;
                  write_type       = 1'b1;
                  cache_in_mux_sel = 1'b1;
               end
            end else if (req) begin
               // An invalid way is never dirty, so only a PLRU victim can need write-back.
               victim_d = inv_any ? inv_way : plru_vict;
               state_d  = (!inv_any && way_dirty[plru_vict]) ? S_WRITEBACK : S_FETCH;
            end
         end
         S_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {victim_tag, idx, {OFF_W{1'b0}}};
            if (pmem_resp) begin
               wb_evt  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            pmem_read = 1'b1;
            if (pmem_resp) state_d = S_INSTALL;
         end
         S_INSTALL: begin
            load_way       = WAYS'(1) << victim_q;
            insert_mux_sel = 1'b1;
            miss_evt       = 1'b1;
            plru_d[idx]    = plru_touch(plru_q[idx], victim_q);
            state_d        = S_HIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_HIT;
         victim_q <= '0;
         for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         plru_q   <= plru_d;
      end
   end

`ifdef L2_PERF_CNT_EN
   logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      wb_cnt_d   = wb_cnt_q;
      if (cnt_clear) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
         wb_cnt_d   = '0;
      end else begin
         if (hit_evt  && hit_cnt_q  != '1) hit_cnt_d  = hit_cnt_q  + 16'd1;
         if (miss_evt && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
         if (wb_evt   && wb_cnt_q   != '1) wb_cnt_d   = wb_cnt_q   + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
   assign wb_count   = wb_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
   assign wb_count   = '0;
   logic unused_cnt;
   assign unused_cnt = ^{cnt_clear, hit_evt, miss_evt, wb_evt};
`endif

   logic unused_off;
   assign unused_off = ^mem_address[OFF_W-1:0];

endmodule
